// File: rtl/multi_edge2en.sv
// rtl/multi_edge2en.sv - multi-channel synchronized, debounced edge-to-enable converter
// Each channel: sync chain -> debounce filter -> edge detect -> masked event -> sticky pending flag.
module multi_edge2en #(
  parameter int CH       = 4,
  parameter int SYNC_STG = 2,
  parameter int DB_CYC   = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] in,
  input  logic [CH-1:0] rise_en,
  input  logic [CH-1:0] fall_en,
  input  logic [CH-1:0] clr,
  output logic [CH-1:0] out,
  output logic [CH-1:0] rising,
  output logic [CH-1:0] falling,
  output logic [CH-1:0] evt,
  output logic [CH-1:0] pend,
  output logic          irq
);

  localparam int CW_RAW = $clog2(DB_CYC + 1);
  localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYC - 1);

  logic [CH-1:0] sync;

  generate
    if (SYNC_STG == 0) begin : g_nosync
      assign sync = in;
    end else begin : g_sync
      logic [CH-1:0] dly_q [SYNC_STG];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < SYNC_STG; i++) dly_q[i] <= '0;
        end else begin
          dly_q[0] <= in;
          for (int i = 1; i < SYNC_STG; i++) dly_q[i] <= dly_q[i-1];
        end
      end

      assign sync = dly_q[SYNC_STG-1];
    end
  endgenerate

  logic [CH-1:0] q_q, q_d;
  logic [CH-1:0] q_dly_q;
  logic [CH-1:0] pend_q, pend_d;
  logic [CW-1:0] cnt_q [CH];
  logic [CW-1:0] cnt_d [CH];

  // A differing level must survive DB_CYC consecutive samples; any match restarts the count.
  always_comb begin
    q_d = q_q;
    for (int c = 0; c < CH; c++) begin
      cnt_d[c] = '0;
      if (sync[c] != q_q[c]) begin
        if (cnt_q[c] == CNT_LAST) begin
          q_d[c] = sync[c];
        end else begin
          cnt_d[c] = cnt_q[c] + CW'(1);
        end
      end
    end
  end

  assign rising  = q_q & ~q_dly_q;
  assign falling = ~q_q & q_dly_q;
  assign evt     = (rising & rise_en) | (falling & fall_en);
  assign pend_d  = (pend_q & ~clr) | evt;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q     <= '0;
      q_dly_q <= '0;
      pend_q  <= '0;
      for (int c = 0; c < CH; c++) cnt_q[c] <= '0;
    end else begin
      q_q     <= q_d;
      q_dly_q <= q_q;
      pend_q  <= pend_d;
      for (int c = 0; c < CH; c++) cnt_q[c] <= cnt_d[c];
    end
  end

  assign out  = q_q;
  assign pend = pend_q;
  assign irq  = |pend_q;

endmodule
